// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage pipeline.
//
// Watches the register specifiers of the instructions in D/E/M/W. It raises
// stall (register enable low) and flush (bubble) controls for the F/D/E/M/W
// pipeline registers. It also produces the forwarding selects for the E-stage
// ALU operand muxes and the D-stage branch comparator muxes. A data-memory
// access that is not ready holds the whole front of the pipe, with a timeout.
//
// Optional feature macro: HAZARD_FWD_EN
//   defined   : forwarding enabled; only load-use and branch-operand hazards stall.
//   undefined : fwd_* tied to 0; any RAW against E/M/W stalls D until W retires.
//
// Ports
//   clk                      clock, rising edge
//   rst                      synchronous reset, active-low
//   rs_d, rt_d               source registers of the instruction in D
//   branch_d, taken_d        D holds a branch/jr; branch/jump resolved taken
//   rs_e, rt_e               source registers of the instruction in E
//   wreg_e/m/w, regwr_e/m/w  destination register and write enable, E/M/W
//   memrd_e, memrd_m         E/M instruction is a load
//   mem_req_m, mem_ready     M data-memory request; memory completes this cycle
//   stall_f/d/e/m            hold stage register (en=0)
//   flush_d/e/w              clear stage register (insert bubble)
//   fwd_a_e, fwd_b_e         E operand select: 00 regfile, 10 from M, 01 from W
//   fwd_a_d, fwd_b_d         D comparator select: 1 = from M
//   mem_err                  sticky data-memory timeout flag
//   stall_cnt                saturating count of cycles with stall_f=1
module hazard_ctrl #(
    parameter int RW     = 5,
    parameter int CNT_W  = 16,
    parameter int MEM_TO = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RW-1:0]    rs_d,
    input  logic [RW-1:0]    rt_d,
    input  logic             branch_d,
    input  logic             taken_d,
    input  logic [RW-1:0]    rs_e,
    input  logic [RW-1:0]    rt_e,
    input  logic [RW-1:0]    wreg_e,
    input  logic [RW-1:0]    wreg_m,
    input  logic [RW-1:0]    wreg_w,
    input  logic             regwr_e,
    input  logic             regwr_m,
    input  logic             regwr_w,
    input  logic             memrd_e,
    input  logic             memrd_m,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              mem_stall;
    logic              lwstall;
    logic              brstall;
    logic              dstall;
    logic [1:0]        fwd_a_e_n;
    logic [1:0]        fwd_b_e_n;
    logic              fwd_a_d_n;
    logic              fwd_b_d_n;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic hit(input logic [RW-1:0] dest, input logic [RW-1:0] src);
        return (dest != '0) && (dest == src);
    endfunction

    // Data-memory wait: the RUN cycle that sees a not-ready request already
    // stalls; in MWAIT the cycle that completes (or times out) releases.
    always_comb begin
        state_nx  = state;
        timeout   = 1'b0;
        mem_stall = 1'b0;
        case (state)
            RUN: begin
                if (mem_req_m && !mem_ready) begin
                    mem_stall = 1'b1;
                    state_nx  = MWAIT;
                end
            end
            MWAIT: begin
                timeout = !mem_ready && (wait_cnt == WAIT_W'(MEM_TO));
                if (mem_ready || timeout) begin
                    state_nx = RUN;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // Load-use: the load in E delivers data too late for the instruction in D.
    // Branch operands: a branch compares in D, so a producer still in E, or a
    // load still in M, cannot be forwarded in time.
    assign lwstall = memrd_e && (hit(rt_e, rs_d) || hit(rt_e, rt_d));
    assign brstall = branch_d &&
                     ((regwr_e && (hit(wreg_e, rs_d) || hit(wreg_e, rt_d))) ||
                      (memrd_m && (hit(wreg_m, rs_d) || hit(wreg_m, rt_d))));

`ifdef HAZARD_FWD_EN
    // Forward selects: the younger producer in M takes priority over W.
    // The D-stage comparator can only take ALU results from M, not load data.
    always_comb begin
        fwd_a_e_n = 2'b00;
        fwd_b_e_n = 2'b00;
        if (regwr_m && hit(wreg_m, rs_e)) begin
            fwd_a_e_n = 2'b10;
        end else if (regwr_w && hit(wreg_w, rs_e)) begin
            fwd_a_e_n = 2'b01;
        end
        if (regwr_m && hit(wreg_m, rt_e)) begin
            fwd_b_e_n = 2'b10;
        end else if (regwr_w && hit(wreg_w, rt_e)) begin
            fwd_b_e_n = 2'b01;
        end
        fwd_a_d_n = regwr_m && hit(wreg_m, rs_d) && !memrd_m;
        fwd_b_d_n = regwr_m && hit(wreg_m, rt_d) && !memrd_m;
    end

    assign dstall = lwstall || brstall;
`else
    logic rawstall;
    logic unused_fwd_srcs;

    // Without forwarding, D waits until every in-flight writer of its sources
    // has retired through W.
    assign rawstall = (regwr_e && (hit(wreg_e, rs_d) || hit(wreg_e, rt_d))) ||
                      (regwr_m && (hit(wreg_m, rs_d) || hit(wreg_m, rt_d))) ||
                      (regwr_w && (hit(wreg_w, rs_d) || hit(wreg_w, rt_d)));
    assign dstall          = rawstall || lwstall || brstall;
    assign fwd_a_e_n       = 2'b00;
    assign fwd_b_e_n       = 2'b00;
    assign fwd_a_d_n       = 1'b0;
    assign fwd_b_d_n       = 1'b0;
    assign unused_fwd_srcs = ^{rs_e, rt_e};
`endif

    // Output priority: reset > memory wait > D-stage hazard > taken-branch squash.
    // A taken branch held by a stall is ignored here; it is seen again when D moves.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        fwd_a_d = 1'b0;
        fwd_b_d = 1'b0;
        if (!rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (dstall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (taken_d) begin
                flush_d = 1'b1;
            end
            fwd_a_e = fwd_a_e_n;
            fwd_b_e = fwd_b_e_n;
            fwd_a_d = fwd_a_d_n;
            fwd_b_d = fwd_b_d_n;
        end
    end

    // State register, wait timer, sticky timeout flag and stall counter.
    // The wait timer only runs while remaining in MWAIT and clears on exit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == MWAIT && state_nx == MWAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
            if (stall_f && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later and registered outputs right after the falling edge. Expectations
// follow the forwarding configuration selected by HAZARD_FWD_EN.
module tb_hazard_ctrl;

    localparam int RW     = 5;
    localparam int CNT_W  = 4;
    localparam int MEM_TO = 4;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    localparam logic [6:0] C_IDLE  = 7'b0000_000;
    localparam logic [6:0] C_RST   = 7'b0000_111;
    localparam logic [6:0] C_DST   = 7'b1100_010;
    localparam logic [6:0] C_MEM   = 7'b1111_001;
    localparam logic [6:0] C_TAKEN = 7'b0000_100;

    logic             clk;
    logic             rst;
    logic [RW-1:0]    rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic             branch_d, taken_d, regwr_e, regwr_m, regwr_w;
    logic             memrd_e, memrd_m, mem_req_m, mem_ready;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w;
    logic [1:0]       fwd_a_e, fwd_b_e;
    logic             fwd_a_d, fwd_b_d;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    logic [6:0]       ctl;
    logic [5:0]       fwd;
    logic [6:0]       exp_ctl;
    logic [5:0]       exp_fwd;
    logic [CNT_W-1:0] exp_cnt;
    int               checks   = 0;
    int               failures = 0;

    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
    assign fwd = {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d};

    hazard_ctrl #(.RW(RW), .CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .taken_d(taken_d),
        .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwr_e(regwr_e), .regwr_m(regwr_m), .regwr_w(regwr_w),
        .memrd_e(memrd_e), .memrd_m(memrd_m),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task clear_inputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        wreg_e = '0; wreg_m = '0; wreg_w = '0;
        branch_d = 1'b0; taken_d = 1'b0;
        regwr_e = 1'b0; regwr_m = 1'b0; regwr_w = 1'b0;
        memrd_e = 1'b0; memrd_m = 1'b0;
        mem_req_m = 1'b0; mem_ready = 1'b0;
    endtask

    task test_reset();
        rst = 1'b0;
        clear_inputs();
        memrd_e = 1'b1; rt_e = 5'd2; rs_d = 5'd2; taken_d = 1'b1; mem_req_m = 1'b1;
        regwr_m = 1'b1; wreg_m = 5'd2; rs_e = 5'd2;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_RST) begin
            failures++;
            $display("[TB] FAIL reset_ctl got=%b exp=%b", ctl, C_RST);
        end
        checks++;
        if (fwd !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_fwd got=%b exp=%b", fwd, 6'b0);
        end
        checks++;
        if (stall_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL reset_cnt got=%0d exp=0", stall_cnt);
        end
        checks++;
        if (mem_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mem_err got=%b exp=0", mem_err);
        end
        rst = 1'b1;
        clear_inputs();
    endtask

    task test_forward();
        @(negedge clk);
        clear_inputs();
        regwr_m = 1'b1; wreg_m = 5'd3; rs_e = 5'd3;
        #1;
        exp_fwd = FWD ? 6'b10_00_0_0 : 6'b0;
        checks++;
        if (fwd !== exp_fwd) begin
            failures++;
            $display("[TB] FAIL fwd_m_rs got=%b exp=%b", fwd, exp_fwd);
        end
        checks++;
        if (ctl !== C_IDLE) begin
            failures++;
            $display("[TB] FAIL fwd_m_rs_ctl got=%b exp=%b", ctl, C_IDLE);
        end

        @(negedge clk);
        regwr_w = 1'b1; wreg_w = 5'd3;
        #1;
        checks++;
        if (fwd !== exp_fwd) begin
            failures++;
            $display("[TB] FAIL fwd_m_over_w got=%b exp=%b", fwd, exp_fwd);
        end

        @(negedge clk);
        rt_e = 5'd7; wreg_w = 5'd7;
        #1;
        exp_fwd = FWD ? 6'b10_01_0_0 : 6'b0;
        checks++;
        if (fwd !== exp_fwd) begin
            failures++;
            $display("[TB] FAIL fwd_w_rt got=%b exp=%b", fwd, exp_fwd);
        end

        @(negedge clk);
        clear_inputs();
        regwr_m = 1'b1; regwr_w = 1'b1;
        #1;
        checks++;
        if (fwd !== 6'b0) begin
            failures++;
            $display("[TB] FAIL fwd_reg0 got=%b exp=%b", fwd, 6'b0);
        end

        @(negedge clk);
        clear_inputs();
        regwr_m = 1'b1; wreg_m = 5'd6; rs_d = 5'd6;
        #1;
        exp_fwd = FWD ? 6'b00_00_1_0 : 6'b0;
        exp_ctl = FWD ? C_IDLE : C_DST;
        checks++;
        if (fwd !== exp_fwd) begin
            failures++;
            $display("[TB] FAIL fwd_d_alu got=%b exp=%b", fwd, exp_fwd);
        end
        checks++;
        if (ctl !== exp_ctl) begin
            failures++;
            $display("[TB] FAIL fwd_d_alu_ctl got=%b exp=%b", ctl, exp_ctl);
        end

        @(negedge clk);
        memrd_m = 1'b1;
        #1;
        checks++;
        if (fwd !== 6'b0) begin
            failures++;
            $display("[TB] FAIL fwd_d_load_blocked got=%b exp=%b", fwd, 6'b0);
        end
        checks++;
        if (ctl !== exp_ctl) begin
            failures++;
            $display("[TB] FAIL fwd_d_load_ctl got=%b exp=%b", ctl, exp_ctl);
        end
    endtask

    task test_load_use();
        logic [CNT_W-1:0] c0;
        @(negedge clk);
        c0 = stall_cnt;
        clear_inputs();
        memrd_e = 1'b1; regwr_e = 1'b1; wreg_e = 5'd2; rt_e = 5'd2; rs_d = 5'd2;
        #1;
        checks++;
        if (ctl !== C_DST) begin
            failures++;
            $display("[TB] FAIL lw_use_stall got=%b exp=%b", ctl, C_DST);
        end

        @(negedge clk);
        exp_cnt = (c0 == '1) ? c0 : c0 + CNT_W'(1);
        checks++;
        if (stall_cnt !== exp_cnt) begin
            failures++;
            $display("[TB] FAIL lw_use_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
        clear_inputs();
        memrd_m = 1'b1; regwr_m = 1'b1; wreg_m = 5'd2; rs_e = 5'd2;
        #1;
        exp_fwd = FWD ? 6'b10_00_0_0 : 6'b0;
        checks++;
        if (fwd !== exp_fwd) begin
            failures++;
            $display("[TB] FAIL lw_fwd_next got=%b exp=%b", fwd, exp_fwd);
        end
        checks++;
        if (ctl !== C_IDLE) begin
            failures++;
            $display("[TB] FAIL lw_released got=%b exp=%b", ctl, C_IDLE);
        end

        @(negedge clk);
        clear_inputs();
        branch_d = 1'b1; rt_d = 5'd2; memrd_m = 1'b1; regwr_m = 1'b1; wreg_m = 5'd2;
        #1;
        checks++;
        if (ctl !== C_DST) begin
            failures++;
            $display("[TB] FAIL br_load_m got=%b exp=%b", ctl, C_DST);
        end

        @(negedge clk);
        clear_inputs();
        branch_d = 1'b1; rs_d = 5'd4; regwr_e = 1'b1; wreg_e = 5'd4;
        #1;
        checks++;
        if (ctl !== C_DST) begin
            failures++;
            $display("[TB] FAIL br_alu_e got=%b exp=%b", ctl, C_DST);
        end

        @(negedge clk);
        clear_inputs();
        memrd_e = 1'b1; regwr_e = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++;
            $display("[TB] FAIL lw_reg0 got=%b exp=%b", ctl, C_IDLE);
        end
    endtask

    task test_taken();
        @(negedge clk);
        clear_inputs();
        taken_d = 1'b1;
        #1;
        checks++;
        if (ctl !== C_TAKEN) begin
            failures++;
            $display("[TB] FAIL taken_flush got=%b exp=%b", ctl, C_TAKEN);
        end

        @(negedge clk);
        memrd_e = 1'b1; rt_e = 5'd9; rt_d = 5'd9;
        #1;
        checks++;
        if (ctl !== C_DST) begin
            failures++;
            $display("[TB] FAIL taken_vs_lwstall got=%b exp=%b", ctl, C_DST);
        end

        @(negedge clk);
        clear_inputs();
        taken_d = 1'b1;
        #1;
        checks++;
        if (ctl !== C_TAKEN) begin
            failures++;
            $display("[TB] FAIL taken_after_release got=%b exp=%b", ctl, C_TAKEN);
        end
    endtask

    task test_raw_pipeline();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            rs_d = 5'd5;
            case (i)
                0: begin regwr_e = 1'b1; wreg_e = 5'd5; end
                1: begin regwr_m = 1'b1; wreg_m = 5'd5; end
                2: begin regwr_w = 1'b1; wreg_w = 5'd5; end
                default: ;
            endcase
            #1;
            exp_ctl = (FWD || i == 3) ? C_IDLE : C_DST;
            exp_fwd = (FWD && i == 1) ? 6'b00_00_1_0 : 6'b0;
            checks++;
            if (ctl !== exp_ctl) begin
                failures++;
                $display("[TB] FAIL raw_ctl_%0d got=%b exp=%b", i, ctl, exp_ctl);
            end
            checks++;
            if (fwd !== exp_fwd) begin
                failures++;
                $display("[TB] FAIL raw_fwd_%0d got=%b exp=%b", i, fwd, exp_fwd);
            end
        end
    endtask

    task test_mem_wait();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (stall_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL mem_cnt_cleared got=%0d exp=0", stall_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            clear_inputs();
            mem_req_m = 1'b1;
            mem_ready = (i == 3);
            if (i == 1) begin
                taken_d = 1'b1; memrd_e = 1'b1; rt_e = 5'd9; rt_d = 5'd9;
            end
            #1;
            exp_ctl = (i < 3) ? C_MEM : C_IDLE;
            checks++;
            if (ctl !== exp_ctl) begin
                failures++;
                $display("[TB] FAIL mem_wait_%0d got=%b exp=%b", i, ctl, exp_ctl);
            end
        end

        @(negedge clk);
        checks++;
        if (stall_cnt !== CNT_W'(3)) begin
            failures++;
            $display("[TB] FAIL mem_wait_cnt got=%0d exp=3", stall_cnt);
        end
        checks++;
        if (mem_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mem_wait_no_err got=%b exp=0", mem_err);
        end
        clear_inputs();
        mem_req_m = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++;
            $display("[TB] FAIL mem_single_cycle got=%b exp=%b", ctl, C_IDLE);
        end
    endtask

    task test_timeout();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_inputs();
            mem_req_m = 1'b1;
            #1;
            exp_ctl = (i < 5) ? C_MEM : C_IDLE;
            checks++;
            if (ctl !== exp_ctl) begin
                failures++;
                $display("[TB] FAIL timeout_cycle_%0d got=%b exp=%b", i, ctl, exp_ctl);
            end
            if (i == 5) begin
                checks++;
                if (mem_err !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL timeout_err_early got=%b exp=0", mem_err);
                end
            end
        end

        @(negedge clk);
        clear_inputs();
        checks++;
        if (mem_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_err_set got=%b exp=1", mem_err);
        end
        checks++;
        if (stall_cnt !== CNT_W'(8)) begin
            failures++;
            $display("[TB] FAIL timeout_cnt got=%0d exp=8", stall_cnt);
        end
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++;
            $display("[TB] FAIL timeout_back_to_run got=%b exp=%b", ctl, C_IDLE);
        end

        @(negedge clk);
        checks++;
        if (mem_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_err_sticky got=%b exp=1", mem_err);
        end
    endtask

    task test_saturation();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear_inputs();
            memrd_e = 1'b1; rt_e = 5'd3; rs_d = 5'd3;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (stall_cnt !== '1) begin
                failures++;
                $display("[TB] FAIL cnt_saturate_%0d got=%0d exp=%0d", i, stall_cnt, {CNT_W{1'b1}});
            end
        end
        checks++;
        if (mem_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_err_sticky got=%b exp=1", mem_err);
        end
        clear_inputs();
    endtask

    task test_reset_mid_wait();
        @(negedge clk);
        clear_inputs();
        mem_req_m = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_MEM) begin
            failures++;
            $display("[TB] FAIL mwait_before_rst got=%b exp=%b", ctl, C_MEM);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RST) begin
            failures++;
            $display("[TB] FAIL rst_overrides_mwait got=%b exp=%b", ctl, C_RST);
        end

        @(negedge clk);
        checks++;
        if (mem_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_clears_err got=%b exp=0", mem_err);
        end
        checks++;
        if (stall_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL rst_clears_cnt got=%0d exp=0", stall_cnt);
        end
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++;
            $display("[TB] FAIL run_after_rst got=%b exp=%b", ctl, C_IDLE);
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        $display("[TB] hazard_ctrl bench, forwarding=%0d", FWD);
        test_reset();
        test_forward();
        test_load_use();
        test_taken();
        test_raw_pipeline();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
